// File: rtl/sipo_pkg.sv
// Shared types for the serial shifters (sipo_deser, piso): FSM state and counter sizing.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter must hold the value WIDTH itself, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input strobes plus the parallel valid/ready output bus of the deserializer.
interface sipo_deser_if #(parameter int WIDTH = 4);
  logic             s_in;
  logic             s_en;
  logic             s_sync;
  logic             p_ready;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;

  modport master (output s_in, s_en, s_sync, p_ready, input  p_out, p_valid);
  modport slave  (input  s_in, s_en, s_sync, p_ready, output p_out, p_valid);
endinterface

// File: rtl/sipo_out_reg.sv
// One-deep valid/ready holding register; a load that finds it full and stalled is dropped
// and raises a sticky overrun.
module sipo_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             overrun
);

  logic accept;
  logic drop;

  // A same-cycle transfer frees the slot, so the new word is still taken.
  assign accept = load & (~valid | ready);
  assign drop   = load & valid & ~ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        q     <= d;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: sync-framed bit collection into a one-deep
// valid/ready output register, with sticky overrun and framing-error flags.
module sipo_deser import sipo_pkg::*; #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  sipo_deser_if.slave      bus,
  input  logic             err_clr,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             frame_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, shift_val, first_val;
  logic [CNT_W-1:0] cnt_n;
  logic             done;
  logic             ferr_set;

  assign shift_val = MSB_FIRST ? {shreg[WIDTH-2:0], bus.s_in} : {bus.s_in, shreg[WIDTH-1:1]};
  // A sync bit starts from a clean word so no stale bits from a cut frame survive.
  assign first_val = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.s_in} : {bus.s_in, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    cnt_n    = bit_cnt;
    done     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_en && bus.s_sync) begin
          shreg_n = first_val;
          cnt_n   = CNT_W'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.s_en) begin
          if (bus.s_sync) begin
            shreg_n  = first_val;
            cnt_n    = CNT_W'(1);
            ferr_set = 1'b1;
          end else begin
            shreg_n = shift_val;
            if (bit_cnt == LAST_CNT) begin
              done    = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = bit_cnt + CNT_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= cnt_n;
      busy    <= (state_n == SHIFT);
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

  sipo_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (done),
    .d       (shreg_n),
    .ready   (bus.p_ready),
    .err_clr (err_clr),
    .q       (bus.p_out),
    .valid   (bus.p_valid),
    .overrun (overrun)
  );

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in parallel-out deserializer. It is the receive-side counterpart of the piso shifter. It collects WIDTH serial bits, framed by a sync strobe, into a parallel word. Completed words go to a one-deep output register with a valid/ready handshake, so reception continues while the consumer stalls. It flags overrun and framing errors.

Parameters:
WIDTH, 4, bits per word (≥2).
MSB_FIRST, 1, 1 = first received bit lands in p_out[WIDTH-1]; 0 = first bit lands in p_out[0].
CNT_W, $clog2(WIDTH+1), width of bit counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
s_in  input  1  serial data bit.
s_en  input  1  bit strobe; s_in is sampled only on cycles where s_en=1.
s_sync  input  1  qualifies the current s_en bit as the first bit of a frame; ignored when s_en=0.
p_ready  input  1  consumer accepts p_out this cycle.
err_clr  input  1  synchronous clear of the sticky error flags.
p_out  output  WIDTH  deserialized word, stable while p_valid=1.
p_valid  output  1  p_out holds an unconsumed word.
busy  output  1  a frame is in progress (state SHIFT).
bit_cnt  output  CNT_W  bits captured in the current frame.
overrun  output  1  sticky: a completed word was dropped because the output register was full.
frame_err  output  1  sticky: s_sync arrived mid-frame.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; shift register, p_out, bit_cnt = 0; p_valid, busy, overrun, frame_err = 0.
- FSM states: IDLE, SHIFT. Registered outputs only.
- IDLE
  - s_en=1 & s_sync=1: capture s_in as bit 1, bit_cnt=1, go to SHIFT.
  - s_en=1 & s_sync=0: bit ignored; stay in IDLE.
- SHIFT
  - s_en=0: hold all state.
  - s_en=1 & s_sync=0: shift in s_in, bit_cnt+1.
  - When the captured bit is bit number WIDTH: word complete, bit_cnt=0, go to IDLE.
  - s_en=1 & s_sync=1 (resync): discard the partial word, capture s_in as bit 1, bit_cnt=1, stay in SHIFT, set frame_err.
- Shift direction
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], s_in}.
  - MSB_FIRST=0: shreg <= {s_in, shreg[WIDTH-1:1]}.
- Completion writes the full word, including the last bit, to the output register. Latency: p_valid rises on the clock edge that samples the last bit, i.e. it is visible the cycle after that bit's s_en.
- Output handshake: transfer occurs when p_valid & p_ready. p_out does not change while p_valid=1 and no transfer occurs.
- Completion with p_valid=0: load p_out, p_valid=1.
- Completion in the same cycle as a transfer: load the new word, p_valid stays 1, no overrun.
- Completion with p_valid=1 & p_ready=0: drop the new word, keep the old p_out, set overrun.
- Transfer with no completion: p_valid=0 next cycle; p_out keeps its last value.
- Sticky flags
  - overrun and frame_err clear only on err_clr=1.
  - err_clr in the same cycle as a new error event: the flag is set (set wins).
- busy = (state==SHIFT).
- A frame may begin on the cycle right after completion. A completion and a new s_sync bit cannot share a cycle, since each cycle carries one bit.
- Reset mid-frame or mid-handshake: the partial word and any pending p_out are lost; no completion is generated.

Decomposition:
- Shared package sipo_pkg: state enum (IDLE=1'b0, SHIFT=1'b1) and a localparam helper for CNT_W. The piso block can reuse the same enum.
- One natural sub-module: sipo_out_reg, the one-deep valid/ready holding register that generates overrun. It is reusable on the piso load side.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset and basic frame: rst=0 for 2 cycles, then release; send 1,0,1,0 with s_sync on the first bit, MSB_FIRST=1, p_ready=1 -> p_out=4'b1010, p_valid pulses for 1 cycle the cycle after the 4th s_en; busy high for cycles 1–3 of the frame.
- LSB order: MSB_FIRST=0, send 1,0,1,0 -> p_out=4'b0101.
- Gapped strobes: same 1,0,1,0 frame with s_en=0 for 3 cycles between each bit -> p_out=4'b1010; bit_cnt steps 1,2,3 and holds across the gaps.
- Backpressure and overrun: p_ready=0; send 4'b1100 then 4'b0011 -> p_out stays 4'b1100, overrun=1; raise p_ready -> p_valid drops; pulse err_clr -> overrun=0.
- Simultaneous completion and transfer: hold p_valid with 4'b1111; complete 4'b0001 while p_ready=1 -> p_out=4'b0001 next cycle, p_valid stays 1, overrun=0.
- Resync and mid-frame reset: send 1,1, then s_sync with bits 0,1,1,0 -> frame_err=1, p_out=4'b0110. Separately, assert rst after 2 bits -> all outputs 0, p_valid never rises.
